// File: rtl/case_mul_pipe_pkg.sv
// case_mul_pkg: shared constants and helpers for the case_mul_pipe multiplier.
// Helpers work on a MAX_W-bit container so one definition serves every width.
package case_mul_pkg;

  localparam int MAX_STAGE = 8;
  localparam int MAX_W     = 64;

  // Full product width for the given operand widths.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Unsigned overflow: any bit in [p_w-1:d_w] is set.
  function automatic logic ovf_unsigned(input logic [MAX_W-1:0] prod,
                                        input int p_w, input int d_w);
    logic any_set;
    any_set = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= d_w && i < p_w && prod[i]) any_set = 1'b1;
    end
    return any_set;
  endfunction

  // Signed overflow: some bit in [p_w-1:d_w] differs from the kept MSB.
  function automatic logic ovf_signed(input logic [MAX_W-1:0] prod,
                                      input int p_w, input int d_w);
    logic msb;
    logic differs;
    msb     = 1'b0;
    differs = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == d_w - 1) msb = prod[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= d_w && i < p_w && (prod[i] != msb)) differs = 1'b1;
    end
    return differs;
  endfunction

  // Largest representable value in d_w bits (signed or unsigned).
  function automatic logic [MAX_W-1:0] sat_max(input int d_w, input logic is_signed);
    logic [MAX_W-1:0] lim;
    lim = '0;
    for (int i = 0; i < MAX_W; i++) begin
      lim[i] = (i < d_w - 1) || ((i == d_w - 1) && !is_signed);
    end
    return lim;
  endfunction

  // Smallest representable value in d_w bits (zero when unsigned).
  function automatic logic [MAX_W-1:0] sat_min(input int d_w, input logic is_signed);
    logic [MAX_W-1:0] lim;
    lim = '0;
    for (int i = 0; i < MAX_W; i++) begin
      lim[i] = (i == d_w - 1) && is_signed;
    end
    return lim;
  endfunction

endpackage

// File: rtl/case_mul_pipe_fmt.sv
// case_mul_pipe_fmt: fits the full product into the result width.
// Extends when the result is wider, otherwise wraps and flags overflow.
// Optional clamp on overflow when CASE_MUL_PIPE_SAT_EN is defined.
module case_mul_pipe_fmt
  import case_mul_pkg::*;
#(
  parameter int P      = 27,
  parameter int DW     = 15,
  parameter int SIGNED = 1
) (
  input  logic [P-1:0]  prod,
  output logic [DW-1:0] dout,
  output logic          ovf
);

  if (DW >= P) begin : g_extend
    if (SIGNED != 0) begin : g_sext
      logic signed [P-1:0] sprod;
      assign sprod = prod;
      assign dout  = DW'(sprod);
    end else begin : g_zext
      assign dout = DW'(prod);
    end
    assign ovf = 1'b0;
  end else begin : g_narrow
    logic [MAX_W-1:0] prod_ext;
    logic             wrap_ovf;
    assign prod_ext = MAX_W'(prod);
    assign wrap_ovf = (SIGNED != 0) ? ovf_signed(prod_ext, P, DW)
                                    : ovf_unsigned(prod_ext, P, DW);
    assign ovf      = wrap_ovf;
`ifdef CASE_MUL_PIPE_SAT_EN
    logic [DW-1:0] lim;
    // Pick the clamp limit from the sign of the full product.
    always_comb begin
      lim = DW'(sat_max(DW, 1'b0));
      if (SIGNED != 0) begin
        lim = prod[P-1] ? DW'(sat_min(DW, 1'b1)) : DW'(sat_max(DW, 1'b1));
      end
    end
    assign dout = wrap_ovf ? lim : prod[DW-1:0];
`else
    assign dout = prod[DW-1:0];
`endif
  end

endmodule

// File: rtl/case_mul_pipe.sv
// case_mul_pipe: pipelined multiplier with valid/ready flow control.
// Stage 0 holds operands, middle stages retime the product, the last stage
// is the formatted result register. Whole pipe freezes while the output
// is valid and not taken. Optional clamp: CASE_MUL_PIPE_SAT_EN.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; in_rdy depends on out_rdy and state only, never on in_vld.
module case_mul_pipe
  import case_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 15,
  parameter int SIGNED     = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P      = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int STAGES = (NUM_STAGE > MAX_STAGE) ? MAX_STAGE :
                          ((NUM_STAGE < 1) ? 1 : NUM_STAGE);

  logic            stall;
  logic            adv;
  logic            accept;
  logic            src_vld;
  logic [P-1:0]    src_prod;
  logic [dout_WIDTH-1:0] fmt_dout;
  logic            fmt_ovf;

  assign stall  = out_vld & ~out_rdy;
  assign adv    = ~stall;
  assign in_rdy = ~ap_rst & ~stall;
  assign accept = in_vld & in_rdy;

  // Extend both operands to P bits; the low P bits of the product are exact.
  function automatic logic [P-1:0] mul_ext(input logic [din0_WIDTH-1:0] a,
                                           input logic [din1_WIDTH-1:0] b);
    logic [P-1:0] ax;
    logic [P-1:0] bx;
    if (SIGNED != 0) begin
      ax = {{(P-din0_WIDTH){a[din0_WIDTH-1]}}, a};
      bx = {{(P-din1_WIDTH){b[din1_WIDTH-1]}}, b};
    end else begin
      ax = {{(P-din0_WIDTH){1'b0}}, a};
      bx = {{(P-din1_WIDTH){1'b0}}, b};
    end
    return ax * bx;
  endfunction

  if (STAGES == 1) begin : g_direct
    assign src_vld  = accept;
    assign src_prod = mul_ext(din0, din1);
  end else begin : g_staged
    logic                  s0_vld;
    logic [din0_WIDTH-1:0] s0_a;
    logic [din1_WIDTH-1:0] s0_b;
    logic [P-1:0]          s0_prod;

    // Operand stage; data only loads on an accepted pair.
    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        s0_vld <= 1'b0;
        s0_a   <= '0;
        s0_b   <= '0;
      end else if (adv) begin
        s0_vld <= accept;
        if (accept) begin
          s0_a <= din0;
          s0_b <= din1;
        end
      end
    end

    assign s0_prod = mul_ext(s0_a, s0_b);

    if (STAGES == 2) begin : g_no_retime
      assign src_vld  = s0_vld;
      assign src_prod = s0_prod;
    end else begin : g_retime
      localparam int RT = STAGES - 2;
      logic [RT-1:0] rt_vld;
      logic [P-1:0]  rt_prod [RT];

      // Retiming shift register for the full product.
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          rt_vld <= '0;
          for (int i = 0; i < RT; i++) rt_prod[i] <= '0;
        end else if (adv) begin
          rt_vld[0] <= s0_vld;
          if (s0_vld) rt_prod[0] <= s0_prod;
          for (int i = 1; i < RT; i++) begin
            rt_vld[i] <= rt_vld[i-1];
            if (rt_vld[i-1]) rt_prod[i] <= rt_prod[i-1];
          end
        end
      end

      assign src_vld  = rt_vld[RT-1];
      assign src_prod = rt_prod[RT-1];
    end
  end

  case_mul_pipe_fmt #(
    .P      (P),
    .DW     (dout_WIDTH),
    .SIGNED (SIGNED)
  ) u_fmt (
    .prod (src_prod),
    .dout (fmt_dout),
    .ovf  (fmt_ovf)
  );

  // Result register; holds while downstream stalls.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_vld <= 1'b0;
      dout    <= '0;
      ovf     <= 1'b0;
    end else if (adv) begin
      out_vld <= src_vld;
      if (src_vld) begin
        dout <= fmt_dout;
        ovf  <= fmt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_case_mul_pipe.sv
// tb_case_mul_pipe: directed and random checks of case_mul_pipe with a
// scoreboard fed from an arithmetic reference of the multiply.
module tb_case_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [14:0] din0;
  logic [11:0] din1;
  logic        out_vld;
  logic        out_rdy;
  logic [14:0] dout;
  logic        ovf;

  logic        u_in_vld;
  logic        u_in_rdy;
  logic [14:0] u_din0;
  logic [11:0] u_din1;
  logic        u_out_vld;
  logic        u_out_rdy;
  logic [26:0] u_dout;
  logic        u_ovf;

  int n_pass   = 0;
  int n_checks = 0;
  int n_out    = 0;

  logic [15:0] exp_q[$];

  case_mul_pipe u_dut (
    .ap_clk (clk), .ap_rst (rst), .in_vld (in_vld), .in_rdy (in_rdy),
    .din0 (din0), .din1 (din1), .out_vld (out_vld), .out_rdy (out_rdy),
    .dout (dout), .ovf (ovf)
  );

  case_mul_pipe #(.SIGNED(0), .dout_WIDTH(27)) u_dut_u (
    .ap_clk (clk), .ap_rst (rst), .in_vld (u_in_vld), .in_rdy (u_in_rdy),
    .din0 (u_din0), .din1 (u_din1), .out_vld (u_out_vld), .out_rdy (u_out_rdy),
    .dout (u_dout), .ovf (u_ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  // Signed reference: true product, 15-bit wrap, overflow if out of range.
  function automatic logic [15:0] model(input logic [14:0] a, input logic [11:0] b);
    longint pa, pb, p;
    logic ov;
    logic [14:0] d;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    ov = (p > 16383) || (p < -16384);
    d  = p[14:0];
`ifdef CASE_MUL_PIPE_SAT_EN
    if (ov) d = (p < 0) ? 15'h4000 : 15'h3FFF;
`endif
    return {ov, d};
  endfunction

  function automatic logic [14:0] rand_a();
    case ($urandom_range(0, 5))
      0: return 15'h4000;
      1: return 15'h3FFF;
      default: return 15'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] rand_b();
    case ($urandom_range(0, 5))
      0: return 12'h800;
      1: return 12'h7FF;
      default: return 12'($urandom);
    endcase
  endfunction

  // Scoreboard: record accepts, compare every valid output against the front.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld) begin
        chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("result", 32'({ovf, dout}), 32'(exp_q[0]));
          if (out_rdy) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_vld && in_rdy) exp_q.push_back(model(din0, din1));
    end
  end

  task automatic send_one(input logic [14:0] a, input logic [11:0] b);
    logic acc;
    acc    = 1'b0;
    in_vld = 1'b1;
    din0   = a;
    din1   = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic u_op(input logic [14:0] a, input logic [11:0] b);
    longint p;
    int     waited;
    p = longint'(a) * longint'(b);
    u_in_vld = 1'b1;
    u_din0   = a;
    u_din1   = b;
    @(negedge clk);
    chk("u_in_rdy", 32'(u_in_rdy), 32'd1);
    @(posedge clk);
    #1;
    u_in_vld = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!u_out_vld && waited < 20) begin
      @(posedge clk);
      waited++;
      @(negedge clk);
    end
    chk("u_out_vld", 32'(u_out_vld), 32'd1);
    chk("u_dout", 32'(u_dout), 32'(p[26:0]));
    chk("u_ovf", 32'(u_ovf), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          first_i;
    int          last_i;
    int          cnt;
    int          sent;
    int          n_out0;
    logic        acc;

    // Reset
    rst = 1'b1; in_vld = 1'b0; din0 = '0; din1 = '0; out_rdy = 1'b1;
    u_in_vld = 1'b0; u_din0 = '0; u_din1 = '0; u_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Single op and latency
    send_one(15'd100, 12'hFFD);
    lat = 0;
    @(negedge clk);
    while (!out_vld && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd2);
    chk("single_dout", 32'(dout), 32'h7ED4);
    chk("single_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Overflow corner
    send_one(15'h4000, 12'h800);
    lat = 0;
    @(negedge clk);
    while (!out_vld && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
`ifdef CASE_MUL_PIPE_SAT_EN
    chk("ovf_dout", 32'(dout), 32'h3FFF);
`else
    chk("ovf_dout", 32'(dout), 32'h0000);
`endif
    chk("ovf_flag", 32'(ovf), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back stream of (i, i+1)
    first_i = -1; last_i = -1; cnt = 0;
    for (int i = 0; i < 24; i++) begin
      in_vld = (i < 16);
      din0   = 15'(i);
      din1   = 12'(i + 1);
      @(negedge clk);
      if (i < 16) chk("stream_in_rdy", 32'(in_rdy), 32'd1);
      if (out_vld) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    chk("stream_count", 32'(cnt), 32'd16);
    chk("stream_span", 32'(last_i - first_i), 32'd15);
    drain();

    // Backpressure mid-stream
    sent = 0;
    in_vld = 1'b1;
    din0 = rand_a();
    din1 = rand_b();
    for (int c = 0; c < 60 && sent < 10; c++) begin
      out_rdy = !(c >= 5 && c < 9);
      @(negedge clk);
      if (c >= 5 && c < 9) begin
        chk("bp_in_rdy", 32'(in_rdy), 32'd0);
        chk("bp_out_vld", 32'(out_vld), 32'd1);
      end
      acc = in_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        din0 = rand_a();
        din1 = rand_b();
      end
    end
    in_vld = 1'b0;
    chk("bp_sent", 32'(sent), 32'd10);
    drain();

    // Reset with two ops in flight
    in_vld = 1'b1;
    din0 = 15'd7; din1 = 12'd9;
    @(posedge clk);
    #1;
    din0 = 15'd11; din1 = 12'd13;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_out_vld", 32'(out_vld), 32'd0);
    end
    @(posedge clk);
    #1;
    n_out0 = n_out;
    send_one(15'h7123, 12'h0A5);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_single_out", 32'(n_out - n_out0), 32'd1);
    drain();

    // Random traffic with random downstream stalls
    for (int i = 0; i < 80; i++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      din0    = rand_a();
      din1    = rand_b();
      out_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    // Unsigned variant
    u_op(15'h7FFF, 12'hFFF);
    for (int i = 0; i < 4; i++) u_op(15'($urandom), 12'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
